// File: rtl/pal_chroma_if.sv
// Sample-side bundle for pal_chroma_modulator: Y/U/V input strobe plus composite output.
// Valid/ready: no ready exists; a sample is taken in every cycle in_valid is high and out_valid marks each produced sample.
interface pal_chroma_if;
    logic       in_valid;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
    logic       line_start;
    logic       burst_en;
    logic       out_valid;
    logic [9:0] out;
    logic       vswitch;

    modport master (
        output in_valid, y, u, v, line_start, burst_en,
        input  out_valid, out, vswitch
    );

    modport slave (
        input  in_valid, y, u, v, line_start, burst_en,
        output out_valid, out, vswitch
    );
endinterface

// File: rtl/pal_chroma_modulator.sv
// PAL chroma modulator and composite mixer: NCO + sine LUT, per-line V-switch, burst insertion, 3-stage pipe.
// Optional: define PAL_CHROMA_LINE_PHASE_RESET_EN to zero the subcarrier phase on every line_start.
module pal_chroma_modulator #(
    parameter int          PHASE_W   = 32,
    parameter int unsigned PHASE_INC = 380844919,
    parameter int          BURST_AMP = 48
) (
    input logic        clk,
    input logic        rst,
    pal_chroma_if.slave bus
);

    localparam logic [PHASE_W-1:0] PHASE_STEP = PHASE_W'(PHASE_INC);
    localparam logic signed [7:0]  BURST_P    = 8'(BURST_AMP);
    localparam logic signed [7:0]  BURST_N    = -BURST_P;

    // Quarter-wave table: round(127*sin(2*pi*i/256)) for i = 0..64.
    function automatic logic [6:0] quarter_sin(input logic [6:0] i);
        logic [6:0] r;
        case (i)
            7'd0:  r = 7'd0;    7'd1:  r = 7'd3;    7'd2:  r = 7'd6;    7'd3:  r = 7'd9;
            7'd4:  r = 7'd12;   7'd5:  r = 7'd16;   7'd6:  r = 7'd19;   7'd7:  r = 7'd22;
            7'd8:  r = 7'd25;   7'd9:  r = 7'd28;   7'd10: r = 7'd31;   7'd11: r = 7'd34;
            7'd12: r = 7'd37;   7'd13: r = 7'd40;   7'd14: r = 7'd43;   7'd15: r = 7'd46;
            7'd16: r = 7'd49;   7'd17: r = 7'd51;   7'd18: r = 7'd54;   7'd19: r = 7'd57;
            7'd20: r = 7'd60;   7'd21: r = 7'd63;   7'd22: r = 7'd65;   7'd23: r = 7'd68;
            7'd24: r = 7'd71;   7'd25: r = 7'd73;   7'd26: r = 7'd76;   7'd27: r = 7'd78;
            7'd28: r = 7'd81;   7'd29: r = 7'd83;   7'd30: r = 7'd85;   7'd31: r = 7'd88;
            7'd32: r = 7'd90;   7'd33: r = 7'd92;   7'd34: r = 7'd94;   7'd35: r = 7'd96;
            7'd36: r = 7'd98;   7'd37: r = 7'd100;  7'd38: r = 7'd102;  7'd39: r = 7'd104;
            7'd40: r = 7'd106;  7'd41: r = 7'd107;  7'd42: r = 7'd109;  7'd43: r = 7'd111;
            7'd44: r = 7'd112;  7'd45: r = 7'd113;  7'd46: r = 7'd115;  7'd47: r = 7'd116;
            7'd48: r = 7'd117;  7'd49: r = 7'd118;  7'd50: r = 7'd120;  7'd51: r = 7'd121;
            7'd52: r = 7'd122;  7'd53: r = 7'd122;  7'd54: r = 7'd123;  7'd55: r = 7'd124;
            7'd56: r = 7'd125;  7'd57: r = 7'd125;  7'd58: r = 7'd126;  7'd59: r = 7'd126;
            7'd60: r = 7'd126;  7'd61: r = 7'd127;  7'd62: r = 7'd127;  7'd63: r = 7'd127;
            7'd64: r = 7'd127;
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    // Full 256-entry sine via quarter-wave symmetry (mirror in odd quadrants, negate in the lower half).
    function automatic logic signed [7:0] sine_lut(input logic [7:0] a);
        logic [6:0] idx;
        logic [6:0] mag;
        idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag = quarter_sin(idx);
        return a[7] ? -{1'b0, mag} : {1'b0, mag};
    endfunction

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_next;
    logic               vswitch_q;
    logic               vsw_eff;
    logic [7:0]         sin_addr;
    logic [7:0]         cos_addr;

    // A sample arriving with line_start already belongs to the new line.
    assign vsw_eff = vswitch_q ^ bus.line_start;

`ifdef PAL_CHROMA_LINE_PHASE_RESET_EN
    assign sin_addr   = bus.line_start ? 8'd0 : phase[PHASE_W-1 -: 8];
    assign phase_next = bus.line_start ? '0 : phase + PHASE_STEP;
`else
    assign sin_addr   = phase[PHASE_W-1 -: 8];
    assign phase_next = phase + PHASE_STEP;
`endif

    assign cos_addr = sin_addr + 8'd64;

    logic signed [7:0] uc_sel;
    logic signed [7:0] vc_raw;
    logic signed [7:0] vc_sel;

    assign uc_sel = bus.burst_en ? BURST_N : $signed(bus.u);
    assign vc_raw = bus.burst_en ? BURST_P : $signed(bus.v);
    // -(-128) does not fit in 8 bits, so it saturates to +127.
    assign vc_sel = !vsw_eff ? vc_raw :
                    (vc_raw == 8'sh80) ? 8'sh7f : -vc_raw;

    // Stage 1 registers
    logic              s1_valid;
    logic [7:0]        s1_y;
    logic signed [7:0] s1_uc;
    logic signed [7:0] s1_vc;
    logic signed [7:0] s1_sin;
    logic signed [7:0] s1_cos;

    // Stage 2 registers
    logic               s2_valid;
    logic [7:0]         s2_y;
    logic signed [15:0] s2_pu;
    logic signed [15:0] s2_pv;

    logic signed [15:0] uc_w;
    logic signed [15:0] vc_w;
    logic signed [15:0] sin_w;
    logic signed [15:0] cos_w;

    assign uc_w  = 16'(s1_uc);
    assign vc_w  = 16'(s1_vc);
    assign sin_w = 16'(s1_sin);
    assign cos_w = 16'(s1_cos);

    logic signed [16:0] sum_w;
    logic signed [11:0] c_w;
    logic signed [11:0] s_w;
    logic [9:0]         out_next;

    assign sum_w = 17'(s2_pu) + 17'(s2_pv);
    assign c_w   = 12'(sum_w >>> 5);
    assign s_w   = $signed({2'b00, s2_y, 2'b00}) + c_w;

    always_comb begin
        out_next = s_w[9:0];
        if (s_w[11]) begin
            out_next = 10'd0;
        end else if (s_w[10]) begin
            out_next = 10'd1023;
        end
    end

    assign bus.vswitch = vswitch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase         <= '0;
            vswitch_q     <= 1'b0;
            s1_valid      <= 1'b0;
            s1_y          <= '0;
            s1_uc         <= '0;
            s1_vc         <= '0;
            s1_sin        <= '0;
            s1_cos        <= '0;
            s2_valid      <= 1'b0;
            s2_y          <= '0;
            s2_pu         <= '0;
            s2_pv         <= '0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
        end else begin
            phase     <= phase_next;
            vswitch_q <= vsw_eff;

            s1_valid <= bus.in_valid;
            s1_y     <= bus.y;
            s1_uc    <= uc_sel;
            s1_vc    <= vc_sel;
            s1_sin   <= sine_lut(sin_addr);
            s1_cos   <= sine_lut(cos_addr);

            s2_valid <= s1_valid;
            s2_y     <= s1_y;
            s2_pu    <= uc_w * sin_w;
            s2_pv    <= vc_w * cos_w;

            // Bubbles leave the last composite value on the output.
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.out <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_pal_chroma_modulator.sv
// Bench for pal_chroma_modulator: one instance at zero subcarrier increment for the fixed-value vectors,
// one at the default increment; both are tracked every cycle by an arithmetic NCO/LUT/clamp reference.
module tb_pal_chroma_modulator;

    localparam int unsigned DEF_INC = 380844919;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid;
    logic [7:0] y, u, v;
    logic       line_start;
    logic       burst_en;

    pal_chroma_if b0 ();
    pal_chroma_if b1 ();

    assign b0.in_valid = in_valid;   assign b1.in_valid = in_valid;
    assign b0.y = y;                 assign b1.y = y;
    assign b0.u = u;                 assign b1.u = u;
    assign b0.v = v;                 assign b1.v = v;
    assign b0.line_start = line_start; assign b1.line_start = line_start;
    assign b0.burst_en = burst_en;   assign b1.burst_en = burst_en;

    pal_chroma_modulator #(.PHASE_INC(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    pal_chroma_modulator dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          lut[256];
    logic [31:0] m_phase[2];
    logic [31:0] m_inc[2];
    logic        m_vsw;
    logic [10:0] exp_q0[$];
    logic [10:0] exp_q1[$];
    int          exp_out[2];
    int          exp_ov[2];

    function automatic int rnd(input real x);
        return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
    endfunction

    function automatic int composite(input int addr);
        int uc, vc, sum, c, s;
        uc = burst_en ? -48 : int'($signed(u));
        vc = burst_en ? 48 : int'($signed(v));
        if (m_vsw) vc = (vc == -128) ? 127 : -vc;
        sum = uc * lut[addr] + vc * lut[(addr + 64) % 256];
        c = int'($floor(real'(sum) / 32.0));
        s = 4 * int'(y) + c;
        if (s < 0) s = 0;
        if (s > 1023) s = 1023;
        return s;
    endfunction

    task automatic model_step();
        logic [31:0] ph;
        logic [10:0] e;
        if (rst) begin
            m_phase[0] = 0; m_phase[1] = 0; m_vsw = 1'b0;
            exp_q0.delete(); exp_q1.delete();
            exp_out[0] = 0; exp_out[1] = 0; exp_ov[0] = 0; exp_ov[1] = 0;
        end else begin
            m_vsw = m_vsw ^ line_start;
            for (int d = 0; d < 2; d++) begin
                ph = m_phase[d];
`ifdef PAL_CHROMA_LINE_PHASE_RESET_EN
                if (line_start) ph = 0;
                m_phase[d] = line_start ? 32'd0 : ph + m_inc[d];
`else
                m_phase[d] = ph + m_inc[d];
`endif
                e = {in_valid, 10'(composite(int'(ph[31:24])))};
                if (d == 0) begin
                    exp_q0.push_back(e);
                    if (exp_q0.size() == 3) e = exp_q0.pop_front(); else e = '0;
                end else begin
                    exp_q1.push_back(e);
                    if (exp_q1.size() == 3) e = exp_q1.pop_front(); else e = '0;
                end
                exp_ov[d] = int'(e[10]);
                if (e[10]) exp_out[d] = int'(e[9:0]);
            end
        end
    endtask

    task automatic check_outs();
        chk("dut0_out_valid", int'(b0.out_valid), exp_ov[0]);
        chk("dut0_out", int'(b0.out), exp_out[0]);
        chk("dut0_vswitch", int'(b0.vswitch), int'(m_vsw));
        chk("dut1_out_valid", int'(b1.out_valid), exp_ov[1]);
        chk("dut1_out", int'(b1.out), exp_out[1]);
        chk("dut1_vswitch", int'(b1.vswitch), int'(m_vsw));
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic set_in(input logic iv, input int yy, input int uu, input int vv, input logic be);
        in_valid = iv; y = 8'(yy); u = 8'(uu); v = 8'(vv); burst_en = be;
    endtask

    typedef struct {
        logic ls;
        logic be;
        int   y, u, v;
        int   exp_out;
        int   exp_vsw;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        for (int k = 0; k < 256; k++) lut[k] = rnd(127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0));
        m_inc[0] = 32'd0;
        m_inc[1] = DEF_INC;

        vecs[0] = '{ls: 0, be: 0, y: 100, u: 0,   v: 0,    exp_out: 400,  exp_vsw: 0};
        vecs[1] = '{ls: 0, be: 0, y: 128, u: 0,   v: 64,   exp_out: 766,  exp_vsw: 0};
        vecs[2] = '{ls: 1, be: 0, y: 128, u: 0,   v: 64,   exp_out: 258,  exp_vsw: 1};
        vecs[3] = '{ls: 1, be: 0, y: 128, u: 0,   v: 64,   exp_out: 766,  exp_vsw: 0};
        vecs[4] = '{ls: 0, be: 1, y: 64,  u: 5,   v: -7,   exp_out: 446,  exp_vsw: 0};
        vecs[5] = '{ls: 1, be: 1, y: 64,  u: -90, v: 33,   exp_out: 65,   exp_vsw: 1};
        vecs[6] = '{ls: 1, be: 0, y: 255, u: 0,   v: 127,  exp_out: 1023, exp_vsw: 0};
        vecs[7] = '{ls: 0, be: 0, y: 0,   u: 0,   v: -128, exp_out: 0,    exp_vsw: 0};
        vecs[8] = '{ls: 1, be: 0, y: 0,   u: 0,   v: -128, exp_out: 504,  exp_vsw: 1};
        vecs[9] = '{ls: 0, be: 0, y: 200, u: 100, v: 0,    exp_out: 800,  exp_vsw: 1};

        // clock/reset
        rst = 1'b1; line_start = 1'b0;
        set_in(1'b0, 0, 0, 0, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // first-sample latency
        set_in(1'b1, 100, 0, 0, 1'b0);
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (b0.out_valid) break;
        end
        chk("latency_cycles", n, 3);
        chk("latency_out", int'(b0.out), 400);
        set_in(1'b0, 0, 0, 0, 1'b0);
        tick();

        // table vectors at zero subcarrier phase
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].ls) begin
                line_start = 1'b1; tick(); line_start = 1'b0;
            end
            set_in(1'b1, vecs[i].y, vecs[i].u, vecs[i].v, vecs[i].be);
            repeat (4) tick();
            chk($sformatf("vec%0d_out", i), int'(b0.out), vecs[i].exp_out);
            chk($sformatf("vec%0d_vswitch", i), int'(b0.vswitch), vecs[i].exp_vsw);
            set_in(1'b0, 0, 0, 0, 1'b0);
            tick();
        end

        // bubble: 1,0,1 -> out_valid 1,0,1 three clocks later, out held in the gap
        repeat (3) tick();
        set_in(1'b1, 10, 0, 0, 1'b0); tick();
        set_in(1'b0, 0, 0, 0, 1'b0);  tick();
        set_in(1'b1, 20, 0, 0, 1'b0); tick();
        chk("bubble_ov0", int'(b0.out_valid), 1); chk("bubble_out0", int'(b0.out), 40);
        set_in(1'b0, 0, 0, 0, 1'b0);  tick();
        chk("bubble_ov1", int'(b0.out_valid), 0); chk("bubble_out1", int'(b0.out), 40);
        tick();
        chk("bubble_ov2", int'(b0.out_valid), 1); chk("bubble_out2", int'(b0.out), 80);

        // reset with samples in flight, line_start during reset ignored
        set_in(1'b1, 90, 20, -20, 1'b0);
        line_start = 1'b1; tick(); tick(); tick();
        rst = 1'b1; tick();
        chk("rst_out", int'(b0.out), 0);
        chk("rst_ov", int'(b0.out_valid), 0);
        chk("rst_vswitch", int'(b0.vswitch), 0);
        chk("rst_out_dut1", int'(b1.out), 0);
        line_start = 1'b0; rst = 1'b0;
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (b0.out_valid) break;
        end
        chk("post_rst_latency", n, 3);
        set_in(1'b0, 0, 0, 0, 1'b0);
        tick();

        // steady tone: u=64, v=0, y=0 at the default increment
        set_in(1'b1, 0, 64, 0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            line_start = (i % 700 == 5);
            tick();
        end
        line_start = 1'b0;

        // randomized traffic
        for (int i = 0; i < 20000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            y          = 8'($urandom_range(0, 255));
            u          = 8'($urandom_range(0, 255));
            v          = 8'($urandom_range(0, 255));
            line_start = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) burst_en = ~burst_en;
            rst        = ($urandom_range(0, 4999) == 0);
            tick();
        end
        rst = 1'b0; line_start = 1'b0;
        set_in(1'b0, 0, 0, 0, 1'b0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
